// File: rtl/noc_params_pkg.sv
// Shared NoC parameters and flit types for the mesh and its network interfaces.
package noc_params;

   localparam int MESH_SIZE_X       = 4;
   localparam int MESH_SIZE_Y       = 4;
   localparam int DEST_ADDR_SIZE_X  = $clog2(MESH_SIZE_X);
   localparam int DEST_ADDR_SIZE_Y  = $clog2(MESH_SIZE_Y);
   localparam int ADDR_NETWORK      = 2;
   localparam int VC_NUM            = 2;
   localparam int VC_SIZE           = $clog2(VC_NUM);
   localparam int FLIT_DATA_SIZE    = 16;
   localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - ADDR_NETWORK - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;
   localparam int MAX_PACKET_LEN    = 16;

   typedef enum logic [1:0] {
      HEAD,
      BODY,
      TAIL,
      HEADTAIL
   } flit_label_t;

   // Head fields are sized so that head_data exactly overlays a body payload word.
   typedef struct packed {
      logic [ADDR_NETWORK-1:0]      sub_network;
      logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
      logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
      logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
   } head_data_t;

   typedef union packed {
      head_data_t                head_data;
      logic [FLIT_DATA_SIZE-1:0] bt_pl;
   } flit_data_t;

   typedef struct packed {
      flit_label_t        flit_label;
      logic [VC_SIZE-1:0] vc_id;
      flit_data_t         data;
   } flit_t;

endpackage

// File: rtl/noc_packetizer_vc_selector.sv
// Picks one VC from the allocatable mask: lowest index by default, or round-robin
// after the last used VC when PACKETIZER_RR_VC_EN is defined.
module vc_selector
   import noc_params::*;
(
`ifdef PACKETIZER_RR_VC_EN
   input  logic               clk,
   input  logic               rst,
   input  logic               advance_i,
`endif
   input  logic [VC_NUM-1:0]  mask_i,
   output logic [VC_SIZE-1:0] vc_o,
   output logic               any_o
);

   assign any_o = |mask_i;

`ifdef PACKETIZER_RR_VC_EN
   logic [VC_SIZE-1:0] ptr_q;
   logic [VC_SIZE-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) begin
         ptr_d = vc_o;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Scan from the farthest offset inward so the nearest candidate after ptr_q wins.
   always_comb begin
      vc_o = '0;
      for (int off = VC_NUM; off >= 1; off--) begin
         if (mask_i[(int'(ptr_q) + off) % VC_NUM]) begin
            vc_o = VC_SIZE'((int'(ptr_q) + off) % VC_NUM);
         end
      end
   end
`else
   always_comb begin
      vc_o = '0;
      for (int i = VC_NUM - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            vc_o = VC_SIZE'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/noc_packetizer.sv
// Injection-side packetizer: turns a packet request plus payload stream into HEAD/BODY/TAIL flits
// for a router LOCAL port. Define PACKETIZER_RR_VC_EN for round-robin VC choice.
module noc_packetizer
   import noc_params::*;
#(
   parameter int MAX_LEN = MAX_PACKET_LEN,
   localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic [ADDR_NETWORK-1:0]      req_sub_network_i,
   input  logic [DEST_ADDR_SIZE_X-1:0]  req_x_i,
   input  logic [DEST_ADDR_SIZE_Y-1:0]  req_y_i,
   input  logic [HEAD_PAYLOAD_SIZE-1:0] req_head_pl_i,
   input  logic [LEN_W-1:0]             req_len_i,
   input  logic                         data_valid_i,
   output logic                         data_ready_o,
   input  logic [FLIT_DATA_SIZE-1:0]    data_pl_i,
   output flit_t                        flit_o,
   output logic                         valid_o,
   input  logic [VC_NUM-1:0]            is_on_off_i,
   input  logic [VC_NUM-1:0]            is_allocatable_i,
   output logic                         busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_VC,
      ST_HEAD,
      ST_BODY
   } state_t;

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic [VC_SIZE-1:0] vc_q, vc_d;
   head_data_t         hdr_q, hdr_d;
   flit_t              flit_q, flit_d;
   logic               valid_q, valid_d;

   logic               on_cur;
   logic               vc_any;
   logic [VC_SIZE-1:0] vc_pick;
   logic               vc_latch;
   logic               head_fire;
   logic               body_fire;

   function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
      if (len == '0) begin
         return LEN_W'(1);
      end
      if (len > LEN_W'(MAX_LEN)) begin
         return LEN_W'(MAX_LEN);
      end
      return len;
   endfunction

   vc_selector u_vc_selector (
`ifdef PACKETIZER_RR_VC_EN
      .clk       (clk),
      .rst       (rst),
      .advance_i (vc_latch),
`endif
      .mask_i    (is_allocatable_i),
      .vc_o      (vc_pick),
      .any_o     (vc_any)
   );

   assign on_cur    = is_on_off_i[vc_q];
   assign vc_latch  = (state_q == ST_WAIT_VC) && vc_any;
   assign head_fire = (state_q == ST_HEAD) && on_cur;
   assign body_fire = (state_q == ST_BODY) && on_cur && data_valid_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               state_d = ST_WAIT_VC;
            end
         end
         ST_WAIT_VC: begin
            if (vc_any) begin
               state_d = ST_HEAD;
            end
         end
         ST_HEAD: begin
            if (head_fire) begin
               state_d = (len_q == LEN_W'(1)) ? ST_IDLE : ST_BODY;
            end
         end
         ST_BODY: begin
            if (body_fire && (rem_q == LEN_W'(1))) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready_o  = (state_q == ST_IDLE);
      busy_o       = (state_q != ST_IDLE);
      data_ready_o = 1'b0;
      if (state_q == ST_BODY) begin
         data_ready_o = on_cur;
      end
   end

   // The flit register only changes on a send, so flit_o holds its last value between pulses.
   always_comb begin
      len_d   = len_q;
      rem_d   = rem_q;
      vc_d    = vc_q;
      hdr_d   = hdr_q;
      flit_d  = flit_q;
      valid_d = 1'b0;

      if ((state_q == ST_IDLE) && req_valid_i) begin
         len_d             = norm_len(req_len_i);
         hdr_d.sub_network = req_sub_network_i;
         hdr_d.x_dest      = req_x_i;
         hdr_d.y_dest      = req_y_i;
         hdr_d.head_pl     = req_head_pl_i;
      end

      if (vc_latch) begin
         vc_d = vc_pick;
      end

      if (head_fire) begin
         valid_d                = 1'b1;
         flit_d.flit_label      = (len_q == LEN_W'(1)) ? HEADTAIL : HEAD;
         flit_d.vc_id           = vc_q;
         flit_d.data.head_data  = hdr_q;
         rem_d                  = len_q - LEN_W'(1);
      end

      if (body_fire) begin
         valid_d           = 1'b1;
         flit_d.flit_label = (rem_q == LEN_W'(1)) ? TAIL : BODY;
         flit_d.vc_id      = vc_q;
         flit_d.data.bt_pl = data_pl_i;
         rem_d             = rem_q - LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_q   <= '0;
         rem_q   <= '0;
         vc_q    <= '0;
         hdr_q   <= '0;
         flit_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         len_q   <= len_d;
         rem_q   <= rem_d;
         vc_q    <= vc_d;
         hdr_q   <= hdr_d;
         flit_q  <= flit_d;
         valid_q <= valid_d;
      end
   end

   assign flit_o  = flit_q;
   assign valid_o = valid_q;

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer; expectations follow PACKETIZER_RR_VC_EN when it is defined.
module tb_noc_packetizer;
   import noc_params::*;

   localparam int LEN_W = $clog2(MAX_PACKET_LEN + 1);
`ifdef PACKETIZER_RR_VC_EN
   localparam bit RR_BUILD = 1'b1;
`else
   localparam bit RR_BUILD = 1'b0;
`endif

   logic                         clk;
   logic                         rst;
   logic                         req_valid_i;
   logic                         req_ready_o;
   logic [ADDR_NETWORK-1:0]      req_sub_network_i;
   logic [DEST_ADDR_SIZE_X-1:0]  req_x_i;
   logic [DEST_ADDR_SIZE_Y-1:0]  req_y_i;
   logic [HEAD_PAYLOAD_SIZE-1:0] req_head_pl_i;
   logic [LEN_W-1:0]             req_len_i;
   logic                         data_valid_i;
   logic                         data_ready_o;
   logic [FLIT_DATA_SIZE-1:0]    data_pl_i;
   flit_t                        flit_o;
   logic                         valid_o;
   logic [VC_NUM-1:0]            is_on_off_i;
   logic [VC_NUM-1:0]            is_allocatable_i;
   logic                         busy_o;

   int total_cnt = 0;
   int bad_cnt   = 0;
   int cyc       = 0;
   int accept_cyc = 0;
   int ready_seen = 0;
   flit_t                     fl_q[$];
   int                        fc_q[$];
   logic [FLIT_DATA_SIZE-1:0] pay_q[$];

   noc_packetizer dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid_i       (req_valid_i),
      .req_ready_o       (req_ready_o),
      .req_sub_network_i (req_sub_network_i),
      .req_x_i           (req_x_i),
      .req_y_i           (req_y_i),
      .req_head_pl_i     (req_head_pl_i),
      .req_len_i         (req_len_i),
      .data_valid_i      (data_valid_i),
      .data_ready_o      (data_ready_o),
      .data_pl_i         (data_pl_i),
      .flit_o            (flit_o),
      .valid_o           (valid_o),
      .is_on_off_i       (is_on_off_i),
      .is_allocatable_i  (is_allocatable_i),
      .busy_o            (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Observe at negedge, then advance inputs just after the posedge; cyc names the observed cycle.
   task automatic stepCycle();
      logic hs;
      logic rq;
      @(negedge clk);
      hs = data_valid_i && data_ready_o;
      rq = req_valid_i && req_ready_o;
      if (valid_o) begin
         fl_q.push_back(flit_o);
         fc_q.push_back(cyc);
      end
      if (data_ready_o) ready_seen++;
      @(posedge clk);
      #1;
      cyc++;
      if (hs && (pay_q.size() > 0)) void'(pay_q.pop_front());
      if (rq && !rst) begin
         req_valid_i = 1'b0;
         accept_cyc  = cyc - 1;
      end
      data_valid_i = (pay_q.size() > 0);
      data_pl_i    = (pay_q.size() > 0) ? pay_q[0] : '0;
   endtask

   task automatic applyStimulus(input int len, input int sub, input int x, input int y, input int hpl);
      fl_q.delete();
      fc_q.delete();
      ready_seen        = 0;
      req_len_i         = LEN_W'(len);
      req_sub_network_i = ADDR_NETWORK'(sub);
      req_x_i           = DEST_ADDR_SIZE_X'(x);
      req_y_i           = DEST_ADDR_SIZE_Y'(y);
      req_head_pl_i     = HEAD_PAYLOAD_SIZE'(hpl);
      req_valid_i       = 1'b1;
      data_valid_i      = (pay_q.size() > 0);
      data_pl_i         = (pay_q.size() > 0) ? pay_q[0] : '0;
   endtask

   task automatic waitAccept(input int maxc);
      int n = 0;
      while (req_valid_i && (n < maxc)) begin
         stepCycle();
         n++;
      end
      if (n >= maxc) checkOutput("accept_timeout", 32'd1, 32'd0);
   endtask

   task automatic runPacket(input int maxc);
      int n = 0;
      while ((busy_o || req_valid_i) && (n < maxc)) begin
         stepCycle();
         n++;
      end
      if (n >= maxc) checkOutput("packet_timeout", 32'd1, 32'd0);
      stepCycle();
   endtask

   function automatic logic [15:0] headWord(input int sub, input int x, input int y, input int hpl);
      head_data_t h;
      h.sub_network = ADDR_NETWORK'(sub);
      h.x_dest      = DEST_ADDR_SIZE_X'(x);
      h.y_dest      = DEST_ADDR_SIZE_Y'(y);
      h.head_pl     = HEAD_PAYLOAD_SIZE'(hpl);
      return h;
   endfunction

   function automatic logic [31:0] vcOf(input int i);
      if (i >= fl_q.size()) return 32'hFFFF;
      return 32'(fl_q[i].vc_id);
   endfunction

   task automatic checkFlit(input int i, input string tag, input flit_label_t lab,
                            input logic [15:0] data, input int c);
      if (i >= fl_q.size()) begin
         checkOutput({tag, "_missing"}, 32'd0, 32'd1);
      end else begin
         checkOutput({tag, "_label"}, 32'(fl_q[i].flit_label), 32'(lab));
         checkOutput({tag, "_data"}, 32'(fl_q[i].data.bt_pl), 32'(data));
         checkOutput({tag, "_cycle"}, fc_q[i], c);
      end
   endtask

   initial begin
      int a;
      int r0;
      logic [31:0] rr_exp[3];

      rst = 1'b1;
      req_valid_i = 1'b0;
      req_sub_network_i = '0;
      req_x_i = '0;
      req_y_i = '0;
      req_head_pl_i = '0;
      req_len_i = '0;
      data_valid_i = 1'b0;
      data_pl_i = '0;
      is_on_off_i = 2'b11;
      is_allocatable_i = 2'b11;

      stepCycle();
      stepCycle();
      checkOutput("rst_valid", 32'(valid_o), 32'd0);
      checkOutput("rst_flit", 32'(flit_o), 32'd0);
      checkOutput("rst_req_ready", 32'(req_ready_o), 32'd1);
      checkOutput("rst_data_ready", 32'(data_ready_o), 32'd0);
      checkOutput("rst_busy", 32'(busy_o), 32'd0);
      rst = 1'b0;
      stepCycle();

      $display("[TB] single-flit packet");
      applyStimulus(1, 1, 3, 2, 'h1A);
      runPacket(20);
      checkOutput("t1_count", fl_q.size(), 32'd1);
      checkFlit(0, "t1_ht", HEADTAIL, headWord(1, 3, 2, 'h1A), accept_cyc + 3);
      checkOutput("t1_vc", vcOf(0), RR_BUILD ? 32'd1 : 32'd0);
      checkOutput("t1_no_data_ready", ready_seen, 32'd0);

      $display("[TB] four-flit packet");
      pay_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
      applyStimulus(4, 2, 1, 0, 'h3FF);
      runPacket(30);
      a = accept_cyc;
      checkOutput("t2_count", fl_q.size(), 32'd4);
      checkFlit(0, "t2_head", HEAD, headWord(2, 1, 0, 'h3FF), a + 3);
      checkFlit(1, "t2_b0", BODY, 16'hAAAA, a + 4);
      checkFlit(2, "t2_b1", BODY, 16'hBBBB, a + 5);
      checkFlit(3, "t2_tail", TAIL, 16'hCCCC, a + 6);
      checkOutput("t2_vc0", vcOf(0), 32'd0);
      for (int i = 1; i < 4; i++) checkOutput("t2_vc_same", vcOf(i), 32'd0);

      $display("[TB] on/off stall in body");
      pay_q = '{16'h1111, 16'h2222};
      applyStimulus(3, 0, 0, 0, 0);
      waitAccept(10);
      a = accept_cyc;
      stepCycle();
      stepCycle();
      is_on_off_i = 2'b00;
      r0 = ready_seen;
      for (int i = 0; i < 3; i++) stepCycle();
      checkOutput("t3_stall_ready", ready_seen - r0, 32'd0);
      checkOutput("t3_stall_kept", pay_q.size(), 32'd2);
      checkOutput("t3_stall_busy", 32'(busy_o), 32'd1);
      is_on_off_i = 2'b11;
      runPacket(20);
      checkOutput("t3_count", fl_q.size(), 32'd3);
      checkFlit(0, "t3_head", HEAD, headWord(0, 0, 0, 0), a + 3);
      checkFlit(1, "t3_b0", BODY, 16'h1111, a + 7);
      checkFlit(2, "t3_tail", TAIL, 16'h2222, a + 8);

      $display("[TB] wait for allocatable VC");
      is_allocatable_i = 2'b00;
      applyStimulus(1, 3, 0, 1, 'h2AA);
      waitAccept(10);
      a = accept_cyc;
      for (int i = 0; i < 5; i++) stepCycle();
      checkOutput("t4_wait_busy", 32'(busy_o), 32'd1);
      checkOutput("t4_wait_req_ready", 32'(req_ready_o), 32'd0);
      checkOutput("t4_wait_noflit", fl_q.size(), 32'd0);
      is_allocatable_i = 2'b10;
      runPacket(20);
      is_allocatable_i = 2'b11;
      checkOutput("t4_count", fl_q.size(), 32'd1);
      checkFlit(0, "t4_ht", HEADTAIL, headWord(3, 0, 1, 'h2AA), a + 8);
      checkOutput("t4_vc", vcOf(0), 32'd1);

      $display("[TB] VC sequence over three packets");
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      rr_exp = RR_BUILD ? '{32'd1, 32'd0, 32'd1} : '{32'd0, 32'd0, 32'd0};
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, k, k, k, k + 5);
         runPacket(20);
         checkOutput("t5_count", fl_q.size(), 32'd1);
         checkOutput("t5_vc", vcOf(0), rr_exp[k]);
      end

      $display("[TB] reset mid-packet");
      pay_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
      applyStimulus(4, 1, 1, 1, 'h055);
      waitAccept(10);
      stepCycle();
      stepCycle();
      stepCycle();
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("t6_valid", 32'(valid_o), 32'd0);
      checkOutput("t6_busy", 32'(busy_o), 32'd0);
      checkOutput("t6_req_ready", 32'(req_ready_o), 32'd1);
      checkOutput("t6_partial_count", fl_q.size(), 32'd2);
      pay_q.delete();
      data_valid_i = 1'b0;
      pay_q = '{16'h5555};
      applyStimulus(2, 2, 2, 2, 'h0F0);
      runPacket(20);
      a = accept_cyc;
      checkOutput("t6_count", fl_q.size(), 32'd2);
      checkFlit(0, "t6_head", HEAD, headWord(2, 2, 2, 'h0F0), a + 3);
      checkFlit(1, "t6_tail", TAIL, 16'h5555, a + 4);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
